// File: rtl/serout_seq.sv
// rtl/serout_seq.sv - SEROUT frame sequencer: holding register, frame FSM and cell-chain strobes
module serout_seq #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enp,
    input  logic                 bit_tick,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 ser_q,
    output logic                 load,
    output logic                 shift,
    output logic [DATA_BITS+1:0] pdata,
    output logic                 sout,
    output logic                 busy,
    output logic                 need_data,
    output logic                 tx_done
);
    localparam int CW = $clog2(DATA_BITS + 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state, state_d;
    logic [DATA_BITS-1:0]   hold, hold_d;
    logic                   hold_full, hold_full_d;
    logic [CW-1:0]          bitcnt, bitcnt_d;
    logic [DATA_BITS+1:0]   pdata_d;
    logic                   load_d, shift_d, need_d, busy_d, tx_done_d;
    logic                   xfer;

    always_comb begin
        state_d     = state;
        hold_d      = hold;
        hold_full_d = hold_full;
        bitcnt_d    = bitcnt;
        pdata_d     = pdata;
        load_d      = load;
        shift_d     = shift;
        need_d      = need_data;
        busy_d      = busy;
        tx_done_d   = tx_done;
        xfer        = 1'b0;

        if (enp) begin
            load_d  = 1'b0;
            shift_d = 1'b0;
            need_d  = 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        xfer    = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (bit_tick) begin
                        if (bitcnt < LAST_BIT) begin
                            shift_d  = 1'b1;
                            bitcnt_d = bitcnt + 1'b1;
                        end else if (hold_full) begin
                            // back-to-back frame: reload straight after the stop bit
                            xfer = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (xfer) begin
                load_d      = 1'b1;
                need_d      = 1'b1;
                pdata_d     = {1'b1, hold, 1'b0};
                hold_full_d = 1'b0;
                bitcnt_d    = '0;
                busy_d      = 1'b1;
                tx_done_d   = 1'b0;
            end else if (state_d == IDLE && !hold_full) begin
                tx_done_d = 1'b1;
            end
        end

        // a write landing on a transfer cycle wins: old data was already copied into pdata_d
        if (wr) begin
            hold_d      = din;
            hold_full_d = 1'b1;
            tx_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            pdata     <= '1;
            load      <= 1'b0;
            shift     <= 1'b0;
            need_data <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b1;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            bitcnt    <= bitcnt_d;
            pdata     <= pdata_d;
            load      <= load_d;
            shift     <= shift_d;
            need_data <= need_d;
            busy      <= busy_d;
            tx_done   <= tx_done_d;
        end
    end

    assign sout = busy ? ser_q : 1'b1;

endmodule

// File: doc/serout_seq.md
SEROUT_SEQ -- requirements
Module: serout_seq

Interface
REQ-001 Parameter: DATA_BITS, default 8, data bits per serial frame. The frame is 1 start bit + DATA_BITS + 1 stop bit (10 bits at default).
REQ-002 clk  in  1  system clock (50 MHz); the only clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 enp  in  1  one-clk-wide enable pulse at each 1.79 MHz slow-clock rising edge; all FSM and strobe updates occur only on enp cycles.
REQ-005 bit_tick  in  1  baud tick from the audio channel; sampled only when enp=1.
REQ-006 wr  in  1  one-clk write strobe to the SEROUT holding register; sampled on any clk cycle.
REQ-007 din  in  DATA_BITS  write data, captured when wr=1.
REQ-008 ser_q  in  1  Q of the last cell in the external shift-cell chain.
REQ-009 load  out  1  parallel-load level to the cell chain; held for exactly one enp period.
REQ-010 shift  out  1  shift level to the cell chain; held for exactly one enp period.
REQ-011 pdata  out  DATA_BITS+2  parallel frame word {1'b1 stop, data, 1'b0 start}; the LSB is shifted out first.
REQ-012 sout  out  1  serial line: ser_q while busy=1, else 1 (marking).
REQ-013 busy  out  1  a frame is in progress.
REQ-014 need_data  out  1  one-enp-period pulse when the holding register is transferred to the frame (SEROUT-needed IRQ source).
REQ-015 tx_done  out  1  level: the transmitter is idle and the holding register is empty.

Function
REQ-016 Holding register: wr=1 stores din and sets hold_full=1. A write while hold_full=1 overwrites the data, with no error flag.
REQ-017 FSM states IDLE and SEND. State changes and all registered outputs update only on clk edges with enp=1.
REQ-018 IDLE, enp=1, hold_full=1:
- load<=1, pdata<={1,hold,0}, hold_full<=0, need_data<=1, bitcnt<=0, busy<=1, tx_done<=0.
- Next state is SEND.
REQ-019 IDLE, enp=1, hold_full=0: load=shift=need_data=0; the FSM stays in IDLE.
REQ-020 In SEND, each enp cycle forces load<=0 and need_data<=0 unless REQ-022 reasserts them.
REQ-021 SEND, enp=1, bit_tick=1, bitcnt<DATA_BITS+1: shift<=1 and bitcnt<=bitcnt+1. With enp=1 and bit_tick=0: shift<=0.
REQ-022 SEND, enp=1, bit_tick=1, bitcnt==DATA_BITS+1 (end of stop bit), shift<=0 and:
- if hold_full=1: perform the REQ-018 load actions and stay in SEND (back-to-back frame, no idle bit);
- otherwise: busy<=0 and enter IDLE.
REQ-023 A load or shift strobe is never asserted in two consecutive enp periods unless caused by two consecutive ticks. load and shift are never both 1.
REQ-024 tx_done is set in IDLE whenever hold_full=0. It is cleared on wr or on a frame start.
REQ-025 wr on the same clk as a transfer (REQ-018/022):
- the transfer uses the old hold contents;
- the new data is stored and hold_full ends at 1 (the write wins).
REQ-026 bit_tick with enp=0 is ignored. bit_tick in IDLE is ignored.
REQ-027 bitcnt is ceil(log2(DATA_BITS+2)) bits wide and never wraps past DATA_BITS+1.

Reset
REQ-028 While rst_n=0, regardless of clk/enp:
- state=IDLE, load=0, shift=0, need_data=0, busy=0, hold_full=0, bitcnt=0;
- pdata=all ones, sout=1, tx_done=1.
REQ-029 Reset asserted mid-frame aborts the frame immediately. After release, the block waits for a new wr; no residual strobes are issued.

Verification
REQ-030 The bench instantiates a behavioural 10-cell chain driven by load/shift/pdata and qualified by enp, and generates bit_tick every 4th enp.
REQ-031 Scenario 1: wr din=8'hA5 while idle -> load for one enp period, pdata=10'h34A; sout carries 0,1,0,1,0,0,1,0,1,1; busy falls after the 10th tick; tx_done=1.
REQ-032 Scenario 2: wr 8'h3C, then wr 8'hF0 during the first frame -> second load coincides with the 10th tick, no marking gap, need_data pulses twice; sout frames carry 0x3C then 0xF0.
REQ-033 Scenario 3: two writes 8'h11 then 8'h22 before the first enp -> only 8'h22 is transmitted; need_data pulses once.
REQ-034 Scenario 4: wr on the same clk as the end-of-frame transfer -> the old byte is sent next and the new byte follows; hold_full ends at 1.
REQ-035 Scenario 5: rst_n low at bit 4 of a frame -> sout=1, busy=0, tx_done=1 within the reset; no load/shift after release until the next wr.
REQ-036 Scenario 6: bit_tick held high continuously -> exactly one shift per enp period, 9 shifts per frame, load and shift never both high.
